// File: rtl/hypot_param.sv
// rtl/hypot_param.sv - iterative floor(sqrt(a^2 + b^2)) / a^2 + b^2 unit with start/busy/done handshake
module hypot_param #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_bi,
    input  logic [W-1:0]   b_bi,
    input  logic           mode_i,
    output logic [W:0]     c_bo,
    output logic [2*W:0]   sq_bo,
    output logic           busy_o,
    output logic           done_o
);

    localparam int CW = $clog2(W + 1) + 1;
    localparam logic [CW-1:0]  K_SQ_LAST = CW'(W - 1);
    localparam logic [CW-1:0]  K_RT_LAST = CW'(W);
    localparam logic [2*W+1:0] M_INIT    = (2*W+2)'(1) << (2*W);

    typedef enum logic [2:0] {
        IDLE,
        SQ_A,
        SQ_B,
        SQRT,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]   a_q, b_q;
    logic           mode_q;
    logic [2*W:0]   acc_q;
    logic [CW-1:0]  k_q;
    logic [2*W+1:0] x_q, r_q, m_q;

    logic [W-1:0]   op;
    logic           op_bit;
    logic [2*W:0]   term;
    logic [2*W:0]   acc_sum;
    logic [2*W+1:0] t;
    logic           ge;

    // Shift-add partial product: operand gated by its own bit k, weighted by 2^k.
    always_comb begin
        op      = (state_q == SQ_B) ? b_q : a_q;
        op_bit  = |(op & (W'(1) << k_q));
        term    = {{(W+1){1'b0}}, op & {W{op_bit}}} << k_q;
        acc_sum = acc_q + term;
        t       = r_q | m_q;
        ge      = (x_q >= t);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = SQ_A;
            SQ_A: if (k_q == K_SQ_LAST) state_d = SQ_B;
            SQ_B: if (k_q == K_SQ_LAST) state_d = mode_q ? FIN : SQRT;
            SQRT: if (k_q == K_RT_LAST) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            k_q    <= '0;
            x_q    <= '0;
            r_q    <= '0;
            m_q    <= '0;
            c_bo   <= '0;
            sq_bo  <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q    <= a_bi;
                        b_q    <= b_bi;
                        mode_q <= mode_i;
                        acc_q  <= '0;
                        k_q    <= '0;
                    end
                end
                SQ_A: begin
                    acc_q <= acc_sum;
                    k_q   <= (k_q == K_SQ_LAST) ? '0 : k_q + CW'(1);
                end
                SQ_B: begin
                    acc_q <= acc_sum;
                    if (k_q == K_SQ_LAST) begin
                        // Radicand taken from the final sum so SQRT starts on the next edge.
                        k_q <= '0;
                        x_q <= {1'b0, acc_sum};
                        r_q <= '0;
                        m_q <= M_INIT;
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                end
                SQRT: begin
                    if (ge) begin
                        x_q <= x_q - t;
                        r_q <= (r_q >> 1) | m_q;
                    end else begin
                        r_q <= r_q >> 1;
                    end
                    m_q <= m_q >> 2;
                    k_q <= k_q + CW'(1);
                end
                FIN: begin
                    sq_bo <= acc_q;
                    if (!mode_q) c_bo <= r_q[W:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_param.sv
// tb/tb_hypot_param.sv - scoreboard bench for hypot_param at W=8 and W=4
module tb_hypot_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start8 = 1'b0, mode8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [8:0]  c8;
    logic [16:0] sq8;
    logic        busy8, done8;
    logic        start4 = 1'b0, mode4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [4:0]  c4;
    logic [8:0]  sq4;
    logic        busy4, done4;

    typedef struct {
        logic [8:0]  c;
        logic [16:0] sq;
        int          lat;
    } exp_t;

    exp_t sb8[$];
    exp_t sb4[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0_8, t0_4;
    int last_c8 = 0;

    hypot_param #(.W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_bi(a8), .b_bi(b8), .mode_i(mode8),
        .c_bo(c8), .sq_bo(sq8), .busy_o(busy8), .done_o(done8)
    );

    hypot_param #(.W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_bi(a4), .b_bi(b4), .mode_i(mode4),
        .c_bo(c4), .sq_bo(sq4), .busy_o(busy4), .done_o(done4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int isqrt(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge with operands scrambled.
    task automatic issue8(input int a, input int b, input bit mode);
        exp_t e;
        e.sq  = 17'(a * a + b * b);
        e.c   = mode ? 9'(last_c8) : 9'(isqrt(a * a + b * b));
        e.lat = mode ? 17 : 26;
        last_c8 = int'(e.c);
        sb8.push_back(e);
        a8 = 8'(a); b8 = 8'(b); mode8 = mode; start8 = 1'b1;
        @(posedge clk); #1;
        t0_8 = cyc;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    endtask

    task automatic issue4(input int a, input int b);
        exp_t e;
        e.sq  = 17'(a * a + b * b);
        e.c   = 9'(isqrt(a * a + b * b));
        e.lat = 14;
        sb4.push_back(e);
        a4 = 4'(a); b4 = 4'(b); mode4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        t0_4 = cyc;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'b1;
    endtask

    task automatic wait_done8;
        while (!done8 && (cyc - t0_8) < 100) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #13 rst = 1'b1;
        #1;
        checks++;
        if (c8 !== 9'd0 || sq8 !== 17'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: c=%0d sq=%0d busy=%b done=%b required all 0", c8, sq8, busy8, done8);
        end
        checks++;
        if (c4 !== 5'd0 || sq4 !== 9'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4: c=%0d sq=%0d busy=%b done=%b required all 0", c4, sq4, busy4, done4);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_norm;
        int ta[4] = '{3, 0, 255, 100};
        int tb[4] = '{4, 0, 255, 1};
        bit tm[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue8(ta[i], tb[i], tm[i]);
            wait_done8();
            e = sb8.pop_front();
            checks++;
            if (!done8) begin
                errors++;
                $display("FAIL norm%0d_timeout: no done within 100 cycles", i);
            end else begin
                if ((cyc - t0_8) !== e.lat) begin
                    errors++;
                    $display("FAIL norm%0d_latency: got %0d required %0d", i, cyc - t0_8, e.lat);
                end
                if (c8 !== e.c || sq8 !== e.sq) begin
                    errors++;
                    $display("FAIL norm%0d_result: c=%0d sq=%0d required c=%0d sq=%0d", i, c8, sq8, e.c, e.sq);
                end
                if (busy8 !== 1'b0) begin
                    errors++;
                    $display("FAIL norm%0d_busy: busy=%b in done cycle required 0", i, busy8);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (done8 !== 1'b0 || c8 !== e.c || sq8 !== e.sq) begin
                errors++;
                $display("FAIL norm%0d_pulse: done=%b c=%0d sq=%0d after pulse required 0/%0d/%0d", i, done8, c8, sq8, e.c, e.sq);
            end
        end
    endtask

    task automatic test_sum_mode;
        exp_t e;
        issue8(255, 255, 1'b0);
        wait_done8();
        void'(sb8.pop_front());
        @(posedge clk); #1;
        issue8(12, 5, 1'b1);
        wait_done8();
        e = sb8.pop_front();
        checks++;
        if (!done8 || (cyc - t0_8) !== 17 || c8 !== 9'd360 || sq8 !== 17'd169 || e.c !== 9'd360) begin
            errors++;
            $display("FAIL sum_mode: done=%b lat=%0d c=%0d sq=%0d required 1/17/360/169", done8, cyc - t0_8, c8, sq8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        issue8(6, 8, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        a8 = 8'd1; b8 = 8'd1; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8();
        e = sb8.pop_front();
        checks++;
        if (!done8 || (cyc - t0_8) !== 26 || c8 !== e.c || sq8 !== e.sq) begin
            errors++;
            $display("FAIL ignore_start: done=%b lat=%0d c=%0d sq=%0d required 1/26/%0d/%0d", done8, cyc - t0_8, c8, sq8, e.c, e.sq);
        end
        issue8(9, 12, 1'b0);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b after accept required 0/1", done8, busy8);
        end
        wait_done8();
        e = sb8.pop_front();
        checks++;
        if (!done8 || (cyc - t0_8) !== 26 || c8 !== 9'd15 || sq8 !== 17'd225 || e.c !== 9'd15) begin
            errors++;
            $display("FAIL b2b_result: done=%b lat=%0d c=%0d sq=%0d required 1/26/15/225", done8, cyc - t0_8, c8, sq8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
            wait_done8();
            e = sb8.pop_front();
            checks++;
            if (!done8 || (cyc - t0_8) !== e.lat || c8 !== e.c || sq8 !== e.sq) begin
                errors++;
                $display("FAIL random%0d: done=%b lat=%0d c=%0d sq=%0d required 1/%0d/%0d/%0d", i, done8, cyc - t0_8, c8, sq8, e.lat, e.c, e.sq);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort;
        bit seen = 1'b0;
        issue8(7, 7, 1'b0);
        void'(sb8.pop_back());
        while ((cyc - t0_8) < 10) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (c8 !== 9'd0 || sq8 !== 17'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: c=%0d sq=%0d busy=%b done=%b required all 0", c8, sq8, busy8, done8);
        end
        last_c8 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: done/busy seen after abort required none");
        end
    endtask

    task automatic test_w4;
        int ta[2] = '{15, 9};
        int tb[2] = '{15, 2};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue4(ta[i], tb[i]);
            while (!done4 && (cyc - t0_4) < 100) begin @(posedge clk); #1; end
            e = sb4.pop_front();
            checks++;
            if (!done4 || (cyc - t0_4) !== e.lat || c4 !== e.c[4:0] || sq4 !== e.sq[8:0]) begin
                errors++;
                $display("FAIL w4_%0d: done=%b lat=%0d c=%0d sq=%0d required 1/%0d/%0d/%0d", i, done4, cyc - t0_4, c4, sq4, e.lat, e.c, e.sq);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_norm();
        test_sum_mode();
        test_back_to_back();
        test_random();
        test_abort();
        test_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
